fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/riscv_pkg.sv | 26 ++
 rtl/fetch_buffer.sv | 65 ++++++
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared core constants, fetch FSM state and fetch buffer entry type.
// FETCH_PREFETCH_EN selects a 2-entry fetch buffer instead of one register.
package riscv_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

`ifdef FETCH_PREFETCH_EN
    localparam int FETCH_BUF_DEPTH = 2;
`else
    localparam int FETCH_BUF_DEPTH = 1;
`endif

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DROP
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Fetch buffer: single register (DEPTH=1) or 2-entry shifting FIFO (DEPTH=2).
// Head is always slot0; flush empties it without touching slot contents.
module fetch_buffer
    import riscv_pkg::*;
#(
    parameter int          DEPTH    = FETCH_BUF_DEPTH,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    localparam fetch_entry_t RST_ENTRY = '{pc: RESET_PC, instr: NOP_INSTR};

    fetch_entry_t slot0;
    fetch_entry_t slot1;
    logic         do_push;
    logic         do_pop;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = slot0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= 2'd0;
            slot0 <= RST_ENTRY;
            slot1 <= RST_ENTRY;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            unique case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0) slot0 <= push_data;
                    else               slot1 <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        slot0 <= push_data;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding imem requests feeding a fetch buffer.
// FETCH_PREFETCH_EN enables a 2-entry buffer so fetch can run ahead of decode.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam logic [2:0] DEPTH = 3'(FETCH_BUF_DEPTH);

    fetch_state_e state;
    logic [31:0]  pc;
    logic [31:0]  target;
    logic [1:0]   count;
    logic [2:0]   avail;
    logic         full;
    logic         empty;
    logic         push;
    logic         pop;
    logic         slot_free;
    logic         refill;
    fetch_entry_t head;

    assign target = {redirect_pc[31:2], 2'b00};
    assign pop    = instr_valid && !stall && !redirect_valid;
    assign push   = (state == WAIT) && imem_rvalid && !redirect_valid;

    // Occupancy once this cycle's consumption is taken into account.
    assign avail     = {1'b0, count} - {2'b00, pop};
    assign slot_free = !full || pop;
    assign refill    = (avail + 3'd1) < DEPTH;

    assign imem_addr   = pc;
    assign instr_valid = !empty;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;

    fetch_buffer #(
        .DEPTH    (FETCH_BUF_DEPTH),
        .RESET_PC (RESET_PC)
    ) u_buf (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ('{pc: pc - 32'd4, instr: imem_rdata}),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            imem_req <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (redirect_valid) begin
                        pc       <= target;
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end else if (slot_free) begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (redirect_valid) begin
                        pc <= target;
                        if (imem_gnt) begin
                            state    <= DROP;
                            imem_req <= 1'b0;
                        end
                    end else if (imem_gnt) begin
                        pc       <= pc + 32'd4;
                        state    <= WAIT;
                        imem_req <= 1'b0;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        pc       <= target;
                        state    <= imem_rvalid ? REQ : DROP;
                        imem_req <= imem_rvalid;
                    end else if (imem_rvalid) begin
                        state    <= refill ? REQ : IDLE;
                        imem_req <= refill;
                    end
                end
                DROP: begin
                    if (redirect_valid) pc <= target;
                    if (imem_rvalid) begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic against a
// program-order reference model of the fetch stream and imem protocol.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int total = 0;
    int bad = 0;

    // Reference model state.
    logic [31:0] oq_addr[$];
    bit          oq_drop[$];
    logic [31:0] gq[$];
    int          occ;
    int          grants;
    logic [31:0] exp_pc;
    logic [31:0] req_pc;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit g, input bit rv, input bit st);
        imem_gnt    = g;
        imem_rvalid = rv;
        stall       = st;
    endtask

    task automatic post_checks();
        chk("instr_valid", 32'(instr_valid), 32'(occ > 0));
        if (occ > 0) begin
            chk("instr_pc", instr_pc, exp_pc);
            chk("instr", instr, mem(exp_pc));
        end
        if (imem_req) begin
            chk("req_addr", imem_addr, req_pc);
            chk("req_legal", 32'(oq_addr.size() == 0 && occ < DEPTH), 32'd1);
        end
    endtask

    task automatic cycle();
        bit          hs;
        bit          cons;
        bit          resp;
        bit          acc;
        logic [31:0] tgt;
        logic [31:0] gaddr;
        if (oq_addr.size() > 0) imem_rdata = mem(oq_addr[0]);
        else                    imem_rdata = 32'hDEAD_BEEF;
        hs    = imem_req && imem_gnt;
        gaddr = imem_addr;
        cons  = instr_valid && !stall;
        resp  = imem_rvalid && (oq_addr.size() > 0);
        acc   = resp && !oq_drop[0] && !redirect_valid;
        tgt   = {redirect_pc[31:2], 2'b00};
        @(posedge clk);
        if (hs) begin
            gq.push_back(gaddr);
            grants++;
            req_pc += 32'd4;
        end
        if (redirect_valid) req_pc = tgt;
        if (resp) begin
            void'(oq_addr.pop_front());
            void'(oq_drop.pop_front());
        end
        if (redirect_valid) foreach (oq_drop[i]) oq_drop[i] = 1'b1;
        if (hs) begin
            oq_addr.push_back(gaddr);
            oq_drop.push_back(redirect_valid);
        end
        if (redirect_valid) begin
            occ    = 0;
            exp_pc = tgt;
        end else begin
            if (cons) begin
                occ--;
                exp_pc += 32'd4;
            end
            if (acc) occ++;
        end
        #1;
        post_checks();
    endtask

    task automatic do_reset();
        rstn           = 1'b0;
        redirect_valid = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_imem_addr", imem_addr, RST_PC);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, NOP);
        chk("rst_instr_pc", instr_pc, RST_PC);
        oq_addr.delete();
        oq_drop.delete();
        gq.delete();
        occ    = 0;
        exp_pc = RST_PC;
        req_pc = RST_PC;
        rstn   = 1'b1;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20 && !instr_valid; i++) cycle();
        chk(tag, 32'(instr_valid), 32'd1);
    endtask

    task automatic reach_wait(input string tag);
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20 && oq_addr.size() == 0; i++) cycle();
        chk(tag, 32'(oq_addr.size()), 32'd1);
    endtask

    initial begin
        #2;
        do_reset();

        // Free-running fetch from reset.
        drive(1'b1, 1'b1, 1'b0);
        wait_valid("first_valid");
        chk("first_instr_pc", instr_pc, RST_PC);
        for (int i = 0; i < 40 && !(instr_valid && instr_pc == 32'h10); i++)
            cycle();
        chk("reach_pc10", 32'(instr_valid && instr_pc == 32'h10), 32'd1);
        chk("grant_cnt", 32'(gq.size() >= 3), 32'd1);
        chk("grant0", gq[0], 32'h0);
        chk("grant1", gq[1], 32'h4);
        chk("grant2", gq[2], 32'h8);

        // Hold the instruction at 0x10 for three cycles.
        drive(1'b1, 1'b1, 1'b1);
        grants = 0;
        repeat (3) begin
            cycle();
            chk("stall_hold_pc", instr_pc, 32'h10);
            chk("stall_hold_instr", instr, mem(32'h10));
        end
        chk("stall_grants", 32'(grants), 32'(DEPTH - 1));
        chk("stall_req_off", 32'(imem_req), 32'd0);
        drive(1'b1, 1'b1, 1'b0);
        repeat (3) cycle();

        // Redirect while waiting, response two cycles later.
        reach_wait("wait_for_drop");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        drive(1'b0, 1'b0, 1'b0);
        cycle();
        redirect_valid = 1'b0;
        cycle();
        drive(1'b0, 1'b1, 1'b0);
        cycle();
        chk("drop_req", 32'(imem_req), 32'd1);
        chk("drop_addr", imem_addr, 32'h100);
        drive(1'b1, 1'b1, 1'b0);
        wait_valid("drop_valid");
        chk("drop_instr_pc", instr_pc, 32'h100);

        // Redirect coincident with the response.
        reach_wait("wait_for_coinc");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        drive(1'b0, 1'b1, 1'b0);
        cycle();
        redirect_valid = 1'b0;
        chk("coinc_req", 32'(imem_req), 32'd1);
        chk("coinc_addr", imem_addr, 32'h200);
        drive(1'b1, 1'b1, 1'b0);
        repeat (4) cycle();

        // Address wrap at the top of memory.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        cycle();
        redirect_valid = 1'b0;
        gq.delete();
        repeat (10) cycle();
        chk("wrap_cnt", 32'(gq.size() >= 2), 32'd1);
        chk("wrap_top", gq[0], 32'hFFFF_FFFC);
        chk("wrap_zero", gq[1], 32'h0);

        // Reset with a request in flight; stale response must be ignored.
        reach_wait("wait_for_reset");
        do_reset();
        drive(1'b0, 1'b1, 1'b0);
        repeat (2) cycle();
        drive(1'b1, 1'b1, 1'b0);
        wait_valid("post_rst_valid");
        chk("post_rst_pc", instr_pc, RST_PC);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom;
            drive($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 9) < 3);
            cycle();
        end
        redirect_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
